ps2_keyboard: RTL and testbench



---
 rtl/vga_pkg.sv | 59 +++++
 rtl/ps2_rx.sv | 157 +++++++++++++++
 rtl/ps2_keyboard.sv | 100 ++++++++++
 tb/tb_ps2_keyboard.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared key codes and PS/2 scancode set 2 constants used by the keyboard
// front end and the menu/game logic that consumes its key codes.
package vga_pkg;

   localparam logic [3:0] key_relesed = 4'd0;
   localparam logic [3:0] key_A       = 4'd1;
   localparam logic [3:0] key_S       = 4'd2;
   localparam logic [3:0] key_W       = 4'd3;
   localparam logic [3:0] key_D       = 4'd4;
   localparam logic [3:0] key_1       = 4'd5;
   localparam logic [3:0] key_2       = 4'd6;
   localparam logic [3:0] key_3       = 4'd7;
   localparam logic [3:0] key_4       = 4'd8;
   localparam logic [3:0] key_esc     = 4'd9;

   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_3     = 8'h26;
   localparam logic [7:0] SC_4     = 8'h25;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef struct packed {
      logic       hit;
      logic [3:0] code;
   } key_lookup_t;

   // PS/2 frames carry odd parity over the 8 data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   function automatic key_lookup_t sc_lookup(input logic [7:0] sc);
      key_lookup_t res;
      res.hit = 1'b1;
      case (sc)
         SC_A:    res.code = key_A;
         SC_S:    res.code = key_S;
         SC_W:    res.code = key_W;
         SC_D:    res.code = key_D;
         SC_1:    res.code = key_1;
         SC_2:    res.code = key_2;
         SC_3:    res.code = key_3;
         SC_4:    res.code = key_4;
         SC_ESC:  res.code = key_esc;
         default: begin
            res.hit  = 1'b0;
            res.code = key_relesed;
         end
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 serial frame receiver: pin synchronizers, clock falling-edge detect,
// start/data/parity/stop framing and an inactivity timeout inside a frame.
module ps2_rx
   import vga_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 13_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   rx_state_t        state_r;
   rx_state_t        state_nxt_s;
   logic [1:0]       clk_sync_r;
   logic [1:0]       data_sync_r;
   logic             clk_prev_r;
   logic             fall_r;
   logic [7:0]       shift_r;
   logic [2:0]       bit_cnt_r;
   logic             par_r;
   logic [CNT_W-1:0] tmo_cnt_r;
   logic [7:0]       rx_byte_r;
   logic             rx_valid_r;
   logic             rx_err_r;
   logic             data_bit_s;
   logic             timeout_s;
   logic             frame_done_s;
   logic             accept_s;
   logic             reject_s;

   assign data_bit_s = data_sync_r[1];
   // A fall in the same cycle restarts the idle count, so it wins over timeout.
   assign timeout_s  = (state_r != IDLE) && !fall_r &&
                       (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES));

   // Two-stage synchronizers and registered falling-edge detect on ps2_clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_r  <= 2'b11;
         data_sync_r <= 2'b11;
         clk_prev_r  <= 1'b1;
         fall_r      <= 1'b0;
      end else begin
         clk_sync_r  <= {clk_sync_r[0], ps2_clk};
         data_sync_r <= {data_sync_r[0], ps2_data};
         clk_prev_r  <= clk_sync_r[1];
         fall_r      <= clk_prev_r & ~clk_sync_r[1];
      end
   end

   // Frame FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Frame FSM next-state logic; every advance happens on a ps2_clk fall.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (fall_r && !data_bit_s) begin
               state_nxt_s = DATA;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DATA: begin
            if (timeout_s) begin
               state_nxt_s = IDLE;
            end else if (fall_r && (bit_cnt_r == 3'd7)) begin
               state_nxt_s = PARITY;
            end else begin
               state_nxt_s = DATA;
            end
         end
         PARITY: begin
            if (timeout_s) begin
               state_nxt_s = IDLE;
            end else if (fall_r) begin
               state_nxt_s = STOP;
            end else begin
               state_nxt_s = PARITY;
            end
         end
         STOP: begin
            if (timeout_s || fall_r) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = STOP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Frame FSM outputs: accept or reject decision at the stop bit.
   always_comb begin
      frame_done_s = (state_r == STOP) && fall_r;
      accept_s     = frame_done_s && data_bit_s && odd_parity_ok(shift_r, par_r);
      reject_s     = (frame_done_s && !accept_s) || timeout_s;
   end

   // Shift register, bit/timeout counters and registered result pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r    <= 8'h00;
         bit_cnt_r  <= 3'd0;
         par_r      <= 1'b0;
         tmo_cnt_r  <= '0;
         rx_byte_r  <= 8'h00;
         rx_valid_r <= 1'b0;
         rx_err_r   <= 1'b0;
      end else begin
         rx_valid_r <= accept_s;
         rx_err_r   <= reject_s;
         if (accept_s) begin
            rx_byte_r <= shift_r;
         end else begin
            rx_byte_r <= rx_byte_r;
         end
         if (fall_r) begin
            tmo_cnt_r <= '0;
            case (state_r)
               IDLE: bit_cnt_r <= 3'd0;
               DATA: begin
                  shift_r   <= {data_bit_s, shift_r[7:1]};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
               end
               PARITY:  par_r <= data_bit_s;
               default: par_r <= par_r;
            endcase
         end else if (state_r != IDLE) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
         end else begin
            tmo_cnt_r <= '0;
         end
      end
   end

   assign rx_byte  = rx_byte_r;
   assign rx_valid = rx_valid_r;
   assign rx_err   = rx_err_r;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: receives frames and decodes scancode set 2
// make/break/extended sequences into the shared 4-bit key codes.
module ps2_keyboard
   import vga_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 13_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       frame_err
);

   logic [7:0]  rx_byte_s;
   logic        rx_valid_s;
   logic        rx_err_s;
   logic        ext_r;
   logic        brk_r;
   logic [3:0]  key_r;
   logic        key_valid_r;
   logic        frame_err_r;
   logic        ext_nxt_s;
   logic        brk_nxt_s;
   logic [3:0]  key_nxt_s;
   logic        key_valid_nxt_s;
   key_lookup_t lookup_s;

   ps2_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk     (clk),
      .rst     (rst),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .rx_byte (rx_byte_s),
      .rx_valid(rx_valid_s),
      .rx_err  (rx_err_s)
   );

   assign lookup_s = sc_lookup(rx_byte_s);

   // Prefix flags persist across rejected frames; only a code byte clears them.
   always_comb begin
      ext_nxt_s       = ext_r;
      brk_nxt_s       = brk_r;
      key_nxt_s       = key_r;
      key_valid_nxt_s = 1'b0;
      if (rx_valid_s) begin
         if (rx_byte_s == SC_EXT) begin
            ext_nxt_s = 1'b1;
         end else if (rx_byte_s == SC_BREAK) begin
            brk_nxt_s = 1'b1;
         end else begin
            ext_nxt_s = 1'b0;
            brk_nxt_s = 1'b0;
            if (ext_r) begin
               key_nxt_s = key_r;
            end else if (brk_r) begin
               if (lookup_s.hit && (lookup_s.code == key_r)) begin
                  key_nxt_s = key_relesed;
               end else begin
                  key_nxt_s = key_r;
               end
            end else if (lookup_s.hit) begin
               key_nxt_s       = lookup_s.code;
               key_valid_nxt_s = 1'b1;
            end else begin
               key_nxt_s = key_r;
            end
         end
      end else begin
         key_valid_nxt_s = 1'b0;
      end
   end

   // Decoder state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         ext_r       <= 1'b0;
         brk_r       <= 1'b0;
         key_r       <= key_relesed;
         key_valid_r <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         ext_r       <= ext_nxt_s;
         brk_r       <= brk_nxt_s;
         key_r       <= key_nxt_s;
         key_valid_r <= key_valid_nxt_s;
         frame_err_r <= rx_err_s;
      end
   end

   assign key       = key_r;
   assign key_valid = key_valid_r;
   assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed key sequences, latency
// probes and randomized frames against a byte-level decoder model.
module tb_ps2_keyboard;

   localparam int TO = 400;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [3:0] key;
   logic       key_valid;
   logic       frame_err;

   ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .key      (key),
      .key_valid(key_valid),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   half = 12;
   logic [3:0] m_key = 4'd0;
   bit   m_ext = 1'b0;
   bit   m_brk = 1'b0;
   int   exp_kv = 0;
   int   exp_err = 0;
   int   seen_kv = 0;
   int   seen_err = 0;
   bit   chk_en = 1'b0;
   logic prev_kv = 1'b0;
   logic prev_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Per-cycle compare against the model plus pulse-shape rules.
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (key !== m_key) begin
            errors++;
            $display("FAIL key: got %0d, expected %0d (cycle %0d)", key, m_key, cyc);
         end
      end
      if (key_valid === 1'b1) seen_kv++;
      if (frame_err === 1'b1) seen_err++;
      if (key_valid === 1'b1 || frame_err === 1'b1) begin
         checks++;
         if ((key_valid && frame_err) || (key_valid && prev_kv) || (frame_err && prev_err)) begin
            errors++;
            $display("FAIL pulse_shape: kv=%0b err=%0b prev_kv=%0b prev_err=%0b", key_valid,
                     frame_err, prev_kv, prev_err);
         end
      end
      prev_kv  <= key_valid;
      prev_err <= frame_err;
   end

   function automatic int map_sc(input logic [7:0] b);
      case (b)
         8'h1C: return 1;
         8'h1B: return 2;
         8'h1D: return 3;
         8'h23: return 4;
         8'h16: return 5;
         8'h1E: return 6;
         8'h26: return 7;
         8'h25: return 8;
         8'h76: return 9;
         default: return 0;
      endcase
   endfunction

   function automatic logic [7:0] sc_of(input int k);
      case (k)
         1: return 8'h1C;
         2: return 8'h1B;
         3: return 8'h1D;
         4: return 8'h23;
         5: return 8'h16;
         6: return 8'h1E;
         7: return 8'h26;
         8: return 8'h25;
         9: return 8'h76;
         default: return 8'h15;
      endcase
   endfunction

   // Byte-level decoder model: prefixes, releases and makes.
   task automatic model_byte(input logic [7:0] b);
      int k;
      k = map_sc(b);
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         if (!m_ext) begin
            if (m_brk) begin
               if (k != 0 && k == int'(m_key)) m_key = 4'd0;
            end else if (k != 0) begin
               m_key = 4'(k);
               exp_kv++;
            end
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic clk_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
      logic par;
      par = ~^b;
      if (bad_par) par = ~par;
      return {bad_stop ? 1'b0 : 1'b1, par, b, 1'b0};
   endfunction

   // kind: 0 good, 1 bad parity, 2 bad stop, 3 truncated after nbits then idle.
   task automatic send_frame(input logic [7:0] b, input int kind, input int nbits);
      logic [10:0] bits;
      int total;
      bits  = frame_bits(b, kind == 1, kind == 2);
      total = (kind == 3) ? nbits : 11;
      for (int i = 0; i < total; i++) begin
         if (i == 10) chk_en = 1'b0;
         clk_bit(bits[i]);
      end
      @(negedge clk);
      ps2_data = 1'b1;
      if (kind == 3) begin
         repeat (TO + 20) @(negedge clk);
         exp_err++;
      end else if (kind == 0) begin
         model_byte(b);
      end else begin
         exp_err++;
      end
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("key_valid_count", seen_kv, exp_kv);
      check("frame_err_count", seen_err, exp_err);
   endtask

   // Good frame whose stop bit is probed for pin-to-fall and fall-to-output latency.
   task automatic send_measured(input logic [7:0] b);
      logic [10:0] bits;
      int k, fc, vc;
      bits = frame_bits(1'b0 ? b : b, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) clk_bit(bits[i]);
      chk_en = 1'b0;
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      k  = cyc;
      fc = -100;
      vc = -100;
      for (int i = 0; i < half; i++) begin
         @(negedge clk);
         if (dut.u_rx.fall_r === 1'b1 && fc < 0) fc = cyc;
         if (key_valid === 1'b1 && vc < 0) vc = cyc;
      end
      ps2_clk = 1'b1;
      repeat (half) @(negedge clk);
      check("pin_to_fall_latency", fc - k, 3);
      check("fall_to_key_valid_latency", vc - fc, 2);
      model_byte(b);
      chk_en = 1'b1;
      check("key_valid_count", seen_kv, exp_kv);
   endtask

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] bits;
      logic [7:0]  pool [15];
      int          r;
      pool = '{8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h76,
               8'hF0, 8'hE0, 8'h15, 8'h75, 8'h00, 8'h5A};
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_key", int'(key), 0);
      check("reset_key_valid", int'(key_valid), 0);
      check("reset_frame_err", int'(frame_err), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;

      // Press and release A.
      send_frame(8'h1C, 0, 0);
      check("press_A", int'(key), 1);
      check("press_A_pulses", exp_kv, 1);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h1C, 0, 0);
      check("release_A", int'(key), 0);
      check("release_A_pulses", exp_kv, 1);

      // Parity error then good S.
      send_frame(8'h1B, 1, 0);
      check("parity_err_key", int'(key), 0);
      check("parity_err_pulses", exp_err, 1);
      send_frame(8'h1B, 0, 0);
      check("press_S", int'(key), 2);

      // Held W survives mismatched release, extended and unmapped codes.
      send_frame(8'h1D, 0, 0);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h23, 0, 0);
      send_frame(8'hE0, 0, 0);
      send_frame(8'h75, 0, 0);
      send_frame(8'h15, 0, 0);
      check("hold_W", int'(key), 3);

      // Timeout mid-frame, then ESC.
      send_frame(8'hA5, 3, 5);
      check("timeout_pulses", exp_err, 2);
      send_frame(8'h76, 0, 0);
      check("press_esc", int'(key), 9);

      // Typematic repeats.
      for (int i = 0; i < 3; i++) send_frame(8'h16, 0, 0);
      check("typematic_key", int'(key), 5);
      check("typematic_pulses", exp_kv, 7);

      // Reset after five bits of a 3-key frame; the tail then looks like a
      // start bit plus five data bits and must time out.
      bits = frame_bits(8'h26, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) clk_bit(bits[i]);
      chk_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      m_key = 4'd0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      for (int i = 5; i < 11; i++) clk_bit(bits[i]);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (TO + 20) @(negedge clk);
      exp_err++;
      check("reset_midframe_key", int'(key), 0);
      check("reset_midframe_kv", seen_kv, exp_kv);
      check("reset_midframe_err", seen_err, exp_err);
      send_frame(8'h26, 0, 0);
      check("press_3", int'(key), 7);

      // Latency probe on a 4-key press.
      send_measured(8'h25);
      check("press_4", int'(key), 8);

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         half = $urandom_range(25, 8);
         r    = $urandom_range(19, 0);
         if (r < 14) send_frame(pool[$urandom_range(14, 0)], 0, 0);
         else if (r == 14) send_frame(pool[$urandom_range(14, 0)], 1, 0);
         else if (r == 15) send_frame(pool[$urandom_range(14, 0)], 2, 0);
         else if (r == 16) send_frame(pool[$urandom_range(14, 0)], 3, $urandom_range(10, 1));
         else if (r == 17) begin
            clk_bit(1'b1);
            send_frame(pool[$urandom_range(14, 0)], 0, 0);
         end else begin
            send_frame(8'hF0, 0, 0);
            send_frame(sc_of(int'(m_key)), 0, 0);
         end
         repeat ($urandom_range(30, 2)) @(negedge clk);
      end
      check("final_kv_count", seen_kv, exp_kv);
      check("final_err_count", seen_err, exp_err);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
